hex_value_overlay: RTL and testbench

//  Pixel-pipeline overlay that renders an NDIGITS-wide hex value as text at a fixed character cell.

---
 rtl/hex_value_overlay.sv | 154 +++++++++++++++
 tb/tb_hex_value_overlay.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_value_overlay.sv
// Pixel-pipeline overlay: renders an NDIGITS hex value as text at a fixed character cell and
// draws a screen border. Three register stages; the font ROM lookup runs between stage 2 and 3.
module hex_value_overlay #(
  parameter int unsigned NDIGITS      = 2,
  parameter int unsigned ZOOM         = 2,
  parameter int unsigned COL          = 9,
  parameter int unsigned ROW          = 8,
  parameter int unsigned FONT_WIDTH   = 8,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter bit          VS_POL       = 1'b0,
  parameter int unsigned BORDER       = 5
) (
  input  logic                    px_clk,
  input  logic                    rst,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    activevideo_in,
  input  logic [9:0]              x_px,
  input  logic [9:0]              y_px,
  input  logic [4*NDIGITS-1:0]    value,
  input  logic [2:0]              fg_color,
  input  logic                    blink_en,
  input  logic                    lz_suppress,
  output logic [FONT_WIDTH-1:0]   char_code,
  output logic [9:0]              font_x,
  output logic [9:0]              font_y,
  input  logic                    font_bit,
  output logic [2:0]              rgb,
  output logic                    hsync,
  output logic                    vsync
);

  localparam int unsigned VW = 4 * NDIGITS;
  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned CS = 3 + ZOOM;
  localparam logic [9:0] COL_W    = 10'(COL);
  localparam logic [9:0] ROW_W    = 10'(ROW);
  localparam logic [9:0] NDIG_W   = 10'(NDIGITS);
  localparam logic [9:0] BORDER_W = 10'(BORDER);
  localparam logic [9:0] X_HI     = 10'(639 - BORDER);
  localparam logic [9:0] Y_HI     = 10'(479 - BORDER);
  localparam logic [CW-1:0] LAST_W = CW'(BLINK_FRAMES - 1);

  logic                  r_s1_hs, r_s1_vs, r_s1_av;
  logic                  r_s2_hs, r_s2_vs, r_s2_av;
  logic                  r_s3_hs, r_s3_vs, r_s3_av;
  logic [9:0]            r_s1_x, r_s1_y, r_s2_x, r_s2_y, r_s3_x, r_s3_y;
  logic [VW-1:0]         r_shadow;
  logic [CW-1:0]         r_frame_cnt;
  logic                  r_blink_phase;
  logic [FONT_WIDTH-1:0] r_char;

  logic                  w_capture;
  logic [9:0]            w_cx, w_cy, w_off;
  logic                  w_is_digit;
  logic [3:0]            w_nibble;
  logic                  w_upper_zero;
  logic                  w_lead_zero;
  logic [FONT_WIDTH-1:0] w_char;

  // Capture on the sync assertion edge so the digits only change between frames.
  assign w_capture = (vsync_in == VS_POL) && (r_s1_vs != VS_POL);

  // Three-stage pipeline of sync, video-enable and pixel coordinates.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      {r_s1_hs, r_s1_vs, r_s1_av} <= '0;
      {r_s2_hs, r_s2_vs, r_s2_av} <= '0;
      {r_s3_hs, r_s3_vs, r_s3_av} <= '0;
      {r_s1_x, r_s1_y, r_s2_x, r_s2_y, r_s3_x, r_s3_y} <= '0;
    end else begin
      {r_s1_hs, r_s1_vs, r_s1_av} <= {hsync_in, vsync_in, activevideo_in};
      {r_s2_hs, r_s2_vs, r_s2_av} <= {r_s1_hs, r_s1_vs, r_s1_av};
      {r_s3_hs, r_s3_vs, r_s3_av} <= {r_s2_hs, r_s2_vs, r_s2_av};
      {r_s1_x, r_s1_y} <= {x_px, y_px};
      {r_s2_x, r_s2_y} <= {r_s1_x, r_s1_y};
      {r_s3_x, r_s3_y} <= {r_s2_x, r_s2_y};
    end
  end

  // Frame-coherent value shadow, frame counter and blink phase.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      r_shadow      <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_capture) begin
      r_shadow <= value;
      if (r_frame_cnt == LAST_W) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Cell decode and character selection from the stage-1 pixel.
  always_comb begin
    w_cx         = r_s1_x >> CS;
    w_cy         = r_s1_y >> CS;
    w_off        = w_cx - COL_W;
    // w_off is only meaningful once cx >= COL has been established.
    w_is_digit   = r_s1_av && (w_cy == ROW_W) && (w_cx >= COL_W) && (w_off < NDIG_W);
    w_nibble     = 4'h0;
    w_lead_zero  = 1'b0;
    w_upper_zero = 1'b1;
    // Walk from the most significant digit, tracking whether everything so far is zero.
    for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
      w_upper_zero = w_upper_zero && (r_shadow[4*i +: 4] == 4'h0);
      if (w_off == 10'(int'(NDIGITS) - 1 - i)) begin
        w_nibble    = r_shadow[4*i +: 4];
        w_lead_zero = w_upper_zero && (i != 0);
      end
    end
    w_char = '0;
    if (w_is_digit && !(blink_en && r_blink_phase) && !(lz_suppress && w_lead_zero)) begin
      if (w_nibble < 4'd10) begin
        w_char = FONT_WIDTH'(8'h30 + {4'h0, w_nibble});
      end else begin
        w_char = FONT_WIDTH'(8'h37 + {4'h0, w_nibble});
      end
    end
  end

  // Register the character code so it lines up with the stage-2 coordinates.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      r_char <= '0;
    end else begin
      r_char <= w_char;
    end
  end

  assign char_code = r_char;
  assign font_x    = r_s2_x >> ZOOM;
  assign font_y    = r_s2_y >> ZOOM;
  assign hsync     = r_s3_hs;
  assign vsync     = r_s3_vs;

  // Stage-3 colour: blanking, then glyph, then border.
  always_comb begin
    rgb = 3'b000;
    if (r_s3_av) begin
      if (font_bit) begin
        rgb = (fg_color == 3'b000) ? 3'b010 : fg_color;
      end else if ((r_s3_x < BORDER_W) || (r_s3_x > X_HI) ||
                   (r_s3_y < BORDER_W) || (r_s3_y > Y_HI)) begin
        rgb = 3'b001;
      end
    end
  end

endmodule

// File: tb/tb_hex_value_overlay.sv
// Bench for hex_value_overlay: a 2-digit and a 4-digit instance share stimulus; a cycle-indexed
// history of inputs drives a reference model of the overlay's display rules.
module tb_hex_value_overlay;

  localparam int ZOOM   = 2;
  localparam int COL    = 9;
  localparam int ROW    = 8;
  localparam int BF     = 2;
  localparam int MAXC   = 16384;

  logic        px_clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in = 1'b0, vsync_in = 1'b1, av_in = 1'b0;
  logic [9:0]  x_px = '0, y_px = '0;
  logic [15:0] value = '0;
  logic [2:0]  fg_color = '0;
  logic        blink_en = 1'b0, lz_suppress = 1'b0, font_bit = 1'b0;

  logic [7:0]  char2, char4;
  logic [9:0]  fx2, fy2, fx4, fy4;
  logic [2:0]  rgb2, rgb4;
  logic        hs2, vs2, hs4, vs4;

  always #5 px_clk = ~px_clk;

  hex_value_overlay #(.NDIGITS(2), .BLINK_FRAMES(BF)) dut2 (
    .px_clk(px_clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .activevideo_in(av_in), .x_px(x_px), .y_px(y_px), .value(value[7:0]),
    .fg_color(fg_color), .blink_en(blink_en), .lz_suppress(lz_suppress),
    .char_code(char2), .font_x(fx2), .font_y(fy2), .font_bit(font_bit),
    .rgb(rgb2), .hsync(hs2), .vsync(vs2)
  );

  hex_value_overlay #(.NDIGITS(4), .BLINK_FRAMES(BF)) dut4 (
    .px_clk(px_clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .activevideo_in(av_in), .x_px(x_px), .y_px(y_px), .value(value),
    .fg_color(fg_color), .blink_en(blink_en), .lz_suppress(lz_suppress),
    .char_code(char4), .font_x(fx4), .font_y(fy4), .font_bit(font_bit),
    .rgb(rgb4), .hsync(hs4), .vsync(vs4)
  );

  typedef struct packed {
    logic        hs, vs, av;
    logic [9:0]  x, y;
    logic [15:0] val;
    logic [2:0]  fg;
    logic        blink, lz, fb;
  } rec_t;

  rec_t        hist    [MAXC];
  logic [15:0] sh_hist [MAXC];
  logic        ph_hist [MAXC];
  int          n = 2;
  logic [15:0] m_shadow = '0;
  int          m_caps = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  string       hexs = "0123456789ABCDEF";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, n, got, exp);
  endtask

  // Character the overlay should emit for pixel p, given shadow/phase and the live controls.
  function automatic logic [7:0] exp_char(input int nd, input rec_t p, input logic [15:0] sh,
                                          input logic ph, input rec_t cur);
    int cx, cy, d, v, nib;
    cx = int'(p.x) >> (3 + ZOOM);
    cy = int'(p.y) >> (3 + ZOOM);
    if (!p.av || cy != ROW || cx < COL || cx - COL >= nd) return 8'h00;
    d = nd - 1 - (cx - COL);
    if (cur.blink && ph) return 8'h00;
    v = int'(sh) & ((1 << (4 * nd)) - 1);
    if (cur.lz && d != 0 && (v >> (4 * d)) == 0) return 8'h00;
    nib = (v >> (4 * d)) & 15;
    return hexs[nib];
  endfunction

  function automatic logic [2:0] exp_rgb(input rec_t p, input rec_t cur);
    if (!p.av) return 3'b000;
    if (cur.fb) return (cur.fg == 3'b000) ? 3'b010 : cur.fg;
    if (p.x < 5 || p.x > 634 || p.y < 5 || p.y > 474) return 3'b001;
    return 3'b000;
  endfunction

  // One clock: record the sampled inputs, advance the model, then check every output.
  task automatic step();
    rec_t r;
    @(posedge px_clk);
    n++;
    r.hs = hsync_in; r.vs = vsync_in; r.av = av_in; r.x = x_px; r.y = y_px;
    r.val = value; r.fg = fg_color; r.blink = blink_en; r.lz = lz_suppress; r.fb = font_bit;
    if (rst) begin
      hist[n] = '0; hist[n-1] = '0; hist[n-2] = '0;
      m_shadow = '0; m_caps = 0;
    end else begin
      hist[n] = r;
      if (r.vs == 1'b0 && hist[n-1].vs != 1'b0) begin
        m_shadow = r.val;
        m_caps++;
      end
    end
    sh_hist[n] = m_shadow;
    ph_hist[n] = ((m_caps / BF) % 2) == 1;
    @(negedge px_clk);
    check("hsync2", 32'(hs2), 32'(hist[n-2].hs));
    check("vsync2", 32'(vs2), 32'(hist[n-2].vs));
    check("hsync4", 32'(hs4), 32'(hist[n-2].hs));
    check("vsync4", 32'(vs4), 32'(hist[n-2].vs));
    check("rgb2", 32'(rgb2), 32'(exp_rgb(hist[n-2], hist[n])));
    check("rgb4", 32'(rgb4), 32'(exp_rgb(hist[n-2], hist[n])));
    check("char2", 32'(char2), 32'(exp_char(2, hist[n-1], sh_hist[n-1], ph_hist[n-1], hist[n])));
    check("char4", 32'(char4), 32'(exp_char(4, hist[n-1], sh_hist[n-1], ph_hist[n-1], hist[n])));
    check("font_x2", 32'(fx2), 32'(hist[n-1].x >> ZOOM));
    check("font_y2", 32'(fy2), 32'(hist[n-1].y >> ZOOM));
    check("font_x4", 32'(fx4), 32'(hist[n-1].x >> ZOOM));
    check("font_y4", 32'(fy4), 32'(hist[n-1].y >> ZOOM));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom); av_in = 1'b1;
    x_px = 10'($urandom_range(0, 639)); y_px = 10'($urandom_range(0, 479));
    #1;
    check("rst_async_rgb", 32'(rgb2), 32'd0);
    check("rst_async_hsync", 32'(hs2), 32'd0);
    check("rst_async_vsync", 32'(vs2), 32'd0);
    check("rst_async_char", 32'(char2), 32'd0);
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic vs_pulse();
    av_in = 1'b0;
    vsync_in = 1'b1; step();
    vsync_in = 1'b0; step(); step();
    vsync_in = 1'b1; step();
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] e2, input logic [7:0] e4,
                     input string tag);
    av_in = 1'b1; x_px = 10'(x); y_px = 10'(y);
    step(); step();
    check({tag, "_c2"}, 32'(char2), 32'(e2));
    check({tag, "_c4"}, 32'(char4), 32'(e4));
  endtask

  task automatic colour(input int x, input int y, input logic av, input logic fb,
                        input logic [2:0] fg, input logic [2:0] e, input string tag);
    av_in = av; x_px = 10'(x); y_px = 10'(y); font_bit = fb; fg_color = fg;
    repeat (3) step();
    check(tag, 32'(rgb2), 32'(e));
    font_bit = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      hist[i] = '0; sh_hist[i] = '0; ph_hist[i] = 1'b0;
    end
    // Reset and sync pass-through
    do_reset();
    for (int i = 0; i < 8; i++) begin
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); step();
    end

    // Digit rendering
    value = 16'h00A7; vs_pulse();
    pix(288, 256, 8'h41, 8'h30, "dig288");
    check("font_x_288", 32'(fx2), 32'd72);
    pix(320, 256, 8'h37, 8'h30, "dig320");
    pix(352, 256, 8'h00, 8'h41, "dig352");
    pix(384, 256, 8'h00, 8'h37, "dig384");
    pix(288, 224, 8'h00, 8'h00, "row7");

    // Frame coherence
    value = 16'h0012; vs_pulse();
    pix(288, 256, 8'h31, 8'h30, "coh_a");
    value = 16'h0034;
    pix(288, 256, 8'h31, 8'h30, "coh_b");
    pix(320, 256, 8'h32, 8'h30, "coh_c");
    vs_pulse();
    pix(288, 256, 8'h33, 8'h30, "coh_d");
    pix(320, 256, 8'h34, 8'h30, "coh_e");
    pix(384, 256, 8'h00, 8'h34, "coh_f");

    // Leading-zero suppression
    value = 16'h0005; lz_suppress = 1'b1; vs_pulse();
    pix(288, 256, 8'h00, 8'h00, "lz1_288");
    pix(320, 256, 8'h35, 8'h00, "lz1_320");
    pix(352, 256, 8'h00, 8'h00, "lz1_352");
    pix(384, 256, 8'h00, 8'h35, "lz1_384");
    lz_suppress = 1'b0;
    pix(288, 256, 8'h30, 8'h30, "lz0_288");
    pix(352, 256, 8'h00, 8'h30, "lz0_352");
    pix(384, 256, 8'h00, 8'h35, "lz0_384");

    // Blinking, counted from a fresh reset
    do_reset();
    blink_en = 1'b1;
    vs_pulse(); pix(320, 256, 8'h35, 8'h30, "blink_f1");
    vs_pulse(); pix(320, 256, 8'h00, 8'h00, "blink_f2");
    vs_pulse(); pix(320, 256, 8'h00, 8'h00, "blink_f3");
    vs_pulse(); pix(320, 256, 8'h35, 8'h30, "blink_f4");
    vs_pulse(); vs_pulse(); pix(384, 256, 8'h00, 8'h00, "blink_f6");
    blink_en = 1'b0;
    pix(384, 256, 8'h00, 8'h35, "blink_off");

    // Colour priority
    colour(100, 100, 1'b1, 1'b1, 3'b000, 3'b010, "rgb_fg0");
    colour(100, 100, 1'b1, 1'b1, 3'b101, 3'b101, "rgb_fg5");
    colour(2, 100, 1'b1, 1'b0, 3'b111, 3'b001, "rgb_border");
    colour(100, 477, 1'b1, 1'b0, 3'b111, 3'b001, "rgb_border_bot");
    colour(100, 100, 1'b0, 1'b1, 3'b111, 3'b000, "rgb_blank");
    colour(100, 100, 1'b1, 1'b0, 3'b111, 3'b000, "rgb_bg");

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      hsync_in = 1'($urandom);
      if ($urandom_range(0, 39) == 0) vsync_in = ~vsync_in;
      av_in = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) begin
        x_px = 10'($urandom_range(280, 420)); y_px = 10'($urandom_range(250, 290));
      end else begin
        x_px = 10'($urandom_range(0, 700)); y_px = 10'($urandom_range(0, 520));
      end
      value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) lz_suppress = ~lz_suppress;
      if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
      fg_color = 3'($urandom);
      font_bit = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
